hamming_secded_decoder: RTL and testbench
=========================================

HAMMING_SECDED_DECODER -- requirements
Module: hamming_secded_decoder

Interface
REQ-001 SHALL have parameter DATA_W, default 4, data bits per word, legal 4..64.
REQ-002 SHALL have parameter CNT_W, default 16, error-counter width.
REQ-003 SHALL have derived localparam P = smallest integer with 2^P >= DATA_W+P+1, and CW = DATA_W+P+1 (codeword width); DATA_W=4 gives P=3, CW=8.
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  codeword present.
REQ-007 SHALL have port in_ready  output  1  block accepts codeword this cycle.
REQ-008 SHALL have port code_in  input  CW  codeword; code_in[i-1] is Hamming position i (1..CW-1); powers of two are check bits; code_in[CW-1] is overall parity.
REQ-009 SHALL have port odd_mode  input  1  0 = even parity, 1 = odd parity; sampled with each accepted word.
REQ-010 SHALL have port out_valid  output  1  decoded word present.
REQ-011 SHALL have port out_ready  input  1  consumer accepts.
REQ-012 SHALL have port data_out  output  DATA_W  corrected data; data bit k = k-th non-power-of-two position, ascending.
REQ-013 SHALL have port err_single  output  1  single error detected and corrected.
REQ-014 SHALL have port err_double  output  1  uncorrectable error; data_out is uncorrected.
REQ-015 SHALL have port err_pos  output  $clog2(CW+1)  corrected position (1..CW), 0 if none.
REQ-016 SHALL have ports corr_cnt, uncorr_cnt  output  CNT_W  saturating error counts.
REQ-017 SHALL have port cnt_clr  input  1  synchronous clear of both counters.

Function
REQ-018 SHALL be a 2-stage pipeline: S1 registers syndrome S (P bits), overall mismatch M, raw word, and mode; S2 registers corrected data and flags; accept-to-out_valid latency 2 cycles.
REQ-019 SHALL compute check j as XOR of all positions with bit j set, inverted when the word's odd_mode=1; M = XOR of all CW bits, inverted when odd_mode=1.
REQ-020 SHALL classify: S=0,M=0 -> clean; S!=0,M=1,S<=CW-1 -> flip position S, err_single, err_pos=S; S=0,M=1 -> data unchanged, err_single, err_pos=CW; S!=0,M=0, or S>CW-1 -> err_double, err_pos=0.
REQ-021 SHALL never assert err_single and err_double together.
REQ-022 SHALL advance both stages only when !(out_valid && !out_ready); in_ready = that same condition; a transfer occurs when valid&&ready.
REQ-023 SHALL hold data_out, flags and err_pos stable while out_valid=1 and out_ready=0.
REQ-024 SHALL propagate bubbles: stage valid bits follow in_valid, no word duplicated or dropped.
REQ-025 SHALL increment corr_cnt/uncorr_cnt once per output transfer with err_single/err_double, saturating at 2^CNT_W-1.
REQ-026 SHALL give cnt_clr priority over a same-cycle increment (counter reads 0 next cycle).
REQ-027 SHALL allow odd_mode to change every word without flushing.

Reset
REQ-028 SHALL on rst_n=0, immediately and asynchronously, clear both stage valids, out_valid, data_out, err_single, err_double, err_pos, corr_cnt and uncorr_cnt to 0.
REQ-029 SHALL discard in-flight words when reset asserts mid-operation; in_ready=1 from the first edge after release.

Structure
REQ-030 SHALL place P/CW derivation functions, the position-to-data-index map and the error-class encoding in shared package hamming_pkg.
REQ-031 SHALL use one sub-module, hamming_syndrome (combinational, parametrised by DATA_W), for S1 syndrome/M generation.

Verification (DATA_W=4)
REQ-032 SHALL check clean word: code_in=8'h55, odd_mode=0 -> 2 cycles later data_out=4'b1011, no flags, err_pos=0.
REQ-033 SHALL check single error: 8'h45 (position 5 flipped) -> data_out=4'b1011, err_single=1, err_pos=5, corr_cnt=1.
REQ-034 SHALL check parity-bit and double errors: 8'hD5 -> data 4'b1011, err_single, err_pos=8; 8'h56 -> err_double, uncorr_cnt increments.
REQ-035 SHALL check odd mode: 8'h5E with odd_mode=1 -> data_out=4'b1011 clean; same word with odd_mode=0 -> error flagged.
REQ-036 SHALL check back-to-back stream with out_ready low 3 cycles -> outputs held, in_ready=0, no loss or reorder.
REQ-037 SHALL check saturation and clear: CNT_W=2, 5 single errors -> corr_cnt=3; cnt_clr with an error transfer the same cycle -> corr_cnt=0; rst_n pulse mid-stream -> out_valid=0 at once.

Source files
------------

// File: rtl/hamming_secded_decoder_pkg.sv
// Shared SECDED helpers: check-bit count, codeword width, data-position map
// and the error-class encoding used by the decoder pipeline.
package hamming_pkg;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_SINGLE = 2'd1,
        ERR_DOUBLE = 2'd2
    } err_class_e;

    // Smallest P with 2^P >= DATA_W + P + 1 (DATA_W up to 64 needs P <= 7).
    function automatic int unsigned calc_p(input int unsigned data_w);
        int unsigned p;
        p = 0;
        for (int unsigned i = 1; i <= 8; i++) begin
            if (p == 0 && (32'd1 << i) >= data_w + i + 1) p = i;
        end
        return p;
    endfunction

    function automatic int unsigned calc_cw(input int unsigned data_w);
        return data_w + calc_p(data_w) + 1;
    endfunction

    function automatic bit is_pow2(input int unsigned x);
        return (x != 0) && ((x & (x - 1)) == 0);
    endfunction

    // Hamming position (1-based) carrying data bit k.
    function automatic int unsigned data_pos(input int unsigned k);
        int unsigned cnt;
        int unsigned pos;
        cnt = 0;
        pos = 0;
        for (int unsigned i = 1; i < 128; i++) begin
            if (!is_pow2(i)) begin
                if (cnt == k && pos == 0) pos = i;
                cnt++;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/hamming_secded_decoder_if.sv
// Codeword-in / decoded-word-out handshake bundle for the SECDED decoder.
interface hamming_secded_decoder_if #(
    parameter int unsigned DATA_W = 4
);
    import hamming_pkg::*;

    localparam int unsigned CW   = calc_cw(DATA_W);
    localparam int unsigned EP_W = $clog2(CW + 1);

    logic              in_valid;
    logic              in_ready;
    logic [CW-1:0]     code_in;
    logic              odd_mode;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] data_out;
    logic              err_single;
    logic              err_double;
    logic [EP_W-1:0]   err_pos;

    modport master (
        output in_valid, code_in, odd_mode, out_ready,
        input  in_ready, out_valid, data_out, err_single, err_double, err_pos
    );

    modport slave (
        input  in_valid, code_in, odd_mode, out_ready,
        output in_ready, out_valid, data_out, err_single, err_double, err_pos
    );

endinterface

// File: rtl/hamming_secded_decoder_syndrome.sv
// Combinational syndrome and overall-parity mismatch for one codeword.
module hamming_syndrome
    import hamming_pkg::*;
#(
    parameter  int unsigned DATA_W = 4,
    localparam int unsigned P      = calc_p(DATA_W),
    localparam int unsigned CW     = DATA_W + P + 1
) (
    input  logic [CW-1:0] i_code,
    input  logic          i_odd,
    output logic [P-1:0]  o_syn,
    output logic          o_mis
);

    always_comb begin
        o_syn = '0;
        for (int unsigned pos = 1; pos < CW; pos++) begin
            for (int unsigned j = 0; j < P; j++) begin
                if (((pos >> j) & 32'd1) != 0) o_syn[j] = o_syn[j] ^ i_code[pos-1];
            end
        end
        if (i_odd) o_syn = ~o_syn;
        o_mis = (^i_code) ^ i_odd;
    end

endmodule

// File: rtl/hamming_secded_decoder.sv
// Two-stage SECDED decoder: S1 latches syndrome/mismatch/raw data, S2 latches
// corrected data and flags; saturating error counters track output transfers.
module hamming_secded_decoder
    import hamming_pkg::*;
#(
    parameter  int unsigned DATA_W = 4,
    parameter  int unsigned CNT_W  = 16,
    localparam int unsigned P      = calc_p(DATA_W),
    localparam int unsigned CW     = DATA_W + P + 1,
    localparam int unsigned EP_W   = $clog2(CW + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CW-1:0]     code_in,
    input  logic              odd_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              err_single,
    output logic              err_double,
    output logic [EP_W-1:0]   err_pos,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt,
    input  logic              cnt_clr
);

    logic [P-1:0]      w_syn;
    logic              w_mis;
    logic [DATA_W-1:0] w_raw_data;
    logic              w_adv;
    logic              w_xfer;
    err_class_e        w_cls;
    logic [EP_W-1:0]   w_pos;
    logic [DATA_W-1:0] w_data;

    logic              r_s1_valid;
    logic [P-1:0]      r_s1_syn;
    logic              r_s1_mis;
    logic [DATA_W-1:0] r_s1_data;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_err_single;
    logic              r_err_double;
    logic [EP_W-1:0]   r_err_pos;
    logic [CNT_W-1:0]  r_corr_cnt;
    logic [CNT_W-1:0]  r_uncorr_cnt;

    hamming_syndrome #(.DATA_W(DATA_W)) u_syndrome (
        .i_code (code_in),
        .i_odd  (odd_mode),
        .o_syn  (w_syn),
        .o_mis  (w_mis)
    );

    // Only data positions are kept in S1; check/parity bits are consumed by the syndrome.
    always_comb begin
        w_raw_data = '0;
        for (int unsigned k = 0; k < DATA_W; k++) w_raw_data[k] = code_in[data_pos(k) - 1];
    end

    assign w_adv  = !(r_out_valid && !out_ready);
    assign w_xfer = r_out_valid && out_ready;

    always_comb begin
        w_cls  = ERR_NONE;
        w_pos  = '0;
        w_data = r_s1_data;
        if (r_s1_syn == '0) begin
            if (r_s1_mis) begin
                w_cls = ERR_SINGLE;
                w_pos = EP_W'(CW);
            end
        end else if (r_s1_mis && 32'(r_s1_syn) <= CW - 1) begin
            w_cls          = ERR_SINGLE;
            w_pos[P-1:0]   = r_s1_syn;
            for (int unsigned k = 0; k < DATA_W; k++) begin
                if (data_pos(k) == 32'(r_s1_syn)) w_data[k] = ~w_data[k];
            end
        end else begin
            w_cls = ERR_DOUBLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_syn     <= '0;
            r_s1_mis     <= 1'b0;
            r_s1_data    <= '0;
            r_out_valid  <= 1'b0;
            r_data       <= '0;
            r_err_single <= 1'b0;
            r_err_double <= 1'b0;
            r_err_pos    <= '0;
        end else if (w_adv) begin
            r_s1_valid   <= in_valid;
            r_s1_syn     <= w_syn;
            r_s1_mis     <= w_mis;
            r_s1_data    <= w_raw_data;
            r_out_valid  <= r_s1_valid;
            r_data       <= w_data;
            r_err_single <= (w_cls == ERR_SINGLE);
            r_err_double <= (w_cls == ERR_DOUBLE);
            r_err_pos    <= w_pos;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else if (cnt_clr) begin
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else if (w_xfer) begin
            if (r_err_single && r_corr_cnt != '1)   r_corr_cnt   <= r_corr_cnt + CNT_W'(1);
            if (r_err_double && r_uncorr_cnt != '1) r_uncorr_cnt <= r_uncorr_cnt + CNT_W'(1);
        end
    end

    assign in_ready   = w_adv;
    assign out_valid  = r_out_valid;
    assign data_out   = r_data;
    assign err_single = r_err_single;
    assign err_double = r_err_double;
    assign err_pos    = r_err_pos;
    assign corr_cnt   = r_corr_cnt;
    assign uncorr_cnt = r_uncorr_cnt;

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Randomized and directed self-checking bench for hamming_secded_decoder
// (DATA_W=4, CNT_W=2) against a syndrome-as-XOR-of-positions reference model.
module tb_hamming_secded_decoder;

    localparam int DW   = 4;
    localparam int CNTW = 2;
    localparam int CMAX = (1 << CNTW) - 1;

    typedef struct {
        logic [3:0] data;
        logic       s;
        logic       d;
        logic [3:0] pos;
    } exp_t;

    typedef struct {
        logic [7:0] cw;
        bit         odd;
        logic [3:0] data;
        logic       s;
        logic       d;
        logic [3:0] pos;
    } dir_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cnt_clr = 1'b0;
    logic [CNTW-1:0] corr_cnt;
    logic [CNTW-1:0] uncorr_cnt;

    int total = 0;
    int bad = 0;
    int m_corr = 0;
    int m_uncorr = 0;
    int dpos[4] = '{3, 5, 6, 7};

    always #5 clk = ~clk;

    hamming_secded_decoder_if #(.DATA_W(DW)) bus ();

    hamming_secded_decoder #(.DATA_W(DW), .CNT_W(CNTW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (bus.in_valid),
        .in_ready   (bus.in_ready),
        .code_in    (bus.code_in),
        .odd_mode   (bus.odd_mode),
        .out_valid  (bus.out_valid),
        .out_ready  (bus.out_ready),
        .data_out   (bus.data_out),
        .err_single (bus.err_single),
        .err_double (bus.err_double),
        .err_pos    (bus.err_pos),
        .corr_cnt   (corr_cnt),
        .uncorr_cnt (uncorr_cnt),
        .cnt_clr    (cnt_clr)
    );

    // Reference: syndrome is the XOR of the indices of all set positions.
    function automatic exp_t model(input logic [7:0] cw, input bit odd);
        exp_t       e;
        int         syn;
        bit         m;
        logic [7:0] fixed;
        syn = 0;
        m   = odd;
        for (int i = 1; i <= 7; i++) if (cw[i-1]) syn = syn ^ i;
        if (odd) syn = syn ^ 7;
        for (int i = 0; i < 8; i++) m = m ^ cw[i];
        fixed = cw;
        e.s = 1'b0; e.d = 1'b0; e.pos = 4'd0;
        if (syn == 0 && m) begin
            e.s = 1'b1; e.pos = 4'd8;
        end else if (syn != 0 && m) begin
            e.s = 1'b1; e.pos = 4'(syn);
            fixed[syn-1] = ~fixed[syn-1];
        end else if (syn != 0) begin
            e.d = 1'b1;
        end
        for (int k = 0; k < 4; k++) e.data[k] = fixed[dpos[k]-1];
        return e;
    endfunction

    function automatic logic [7:0] encode(input logic [3:0] d, input bit odd);
        logic [7:0] c;
        bit         p;
        c = '0;
        for (int k = 0; k < 4; k++) c[dpos[k]-1] = d[k];
        for (int j = 0; j < 3; j++) begin
            p = odd;
            for (int i = 1; i <= 7; i++) if (i != (1 << j) && ((i >> j) & 1) == 1) p = p ^ c[i-1];
            c[(1 << j) - 1] = p;
        end
        c[7] = odd ^ (^c[6:0]);
        return c;
    endfunction

    function automatic logic [7:0] gen_word(input bit odd);
        logic [7:0] c;
        int         i;
        int         j;
        c = encode(4'($urandom), odd);
        case ($urandom_range(0, 3))
            1: c[$urandom_range(0, 7)] = ~c[$urandom_range(0, 7)];
            2: begin
                i = $urandom_range(0, 7);
                j = (i + 1 + $urandom_range(0, 6)) % 8;
                c[i] = ~c[i];
                c[j] = ~c[j];
            end
            3: c = 8'($urandom);
            default: ;
        endcase
        return c;
    endfunction

    task automatic send(input logic [7:0] cw, input bit odd);
        bus.in_valid = 1'b1;
        bus.code_in  = cw;
        bus.odd_mode = odd;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output bit ok, output int lat);
        ok  = 1'b0;
        lat = 1;
        for (int i = 0; i < 20; i++) begin
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        bus.in_valid  = 1'b0;
        bus.code_in   = '0;
        bus.odd_mode  = 1'b0;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        end
        total++;
        if ({bus.data_out, bus.err_single, bus.err_double, bus.err_pos} !== 10'd0) begin
            bad++; $display("FAIL reset_outputs: got %h want 000",
                            {bus.data_out, bus.err_single, bus.err_double, bus.err_pos});
        end
        total++;
        if ({corr_cnt, uncorr_cnt} !== '0) begin
            bad++; $display("FAIL reset_counters: got %0d/%0d want 0/0", corr_cnt, uncorr_cnt);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_directed;
        dir_t tbl[6];
        bit   ok;
        int   lat;
        tbl = '{
            '{8'h55, 1'b0, 4'b1011, 1'b0, 1'b0, 4'd0},
            '{8'h45, 1'b0, 4'b1011, 1'b1, 1'b0, 4'd5},
            '{8'hD5, 1'b0, 4'b1011, 1'b1, 1'b0, 4'd8},
            '{8'h56, 1'b0, 4'b1011, 1'b0, 1'b1, 4'd0},
            '{8'h5E, 1'b1, 4'b1011, 1'b0, 1'b0, 4'd0},
            '{8'h5E, 1'b0, 4'b0011, 1'b1, 1'b0, 4'd7}
        };
        bus.out_ready = 1'b1;
        for (int t = 0; t < 6; t++) begin
            send(tbl[t].cw, tbl[t].odd);
            wait_out(ok, lat);
            total++;
            if (!ok) begin
                bad++; $display("FAIL dir%0d_timeout: got no out_valid want out_valid", t);
            end
            if (t == 0) begin
                total++;
                if (lat != 2) begin
                    bad++; $display("FAIL dir_latency: got %0d want 2", lat);
                end
            end
            total++;
            if ({bus.data_out, bus.err_single, bus.err_double, bus.err_pos} !==
                {tbl[t].data, tbl[t].s, tbl[t].d, tbl[t].pos}) begin
                bad++; $display("FAIL dir%0d_word %h: got data=%b s=%b d=%b pos=%0d want data=%b s=%b d=%b pos=%0d",
                                t, tbl[t].cw, bus.data_out, bus.err_single, bus.err_double, bus.err_pos,
                                tbl[t].data, tbl[t].s, tbl[t].d, tbl[t].pos);
            end
            @(negedge clk);
            if (tbl[t].s && m_corr < CMAX)   m_corr++;
            if (tbl[t].d && m_uncorr < CMAX) m_uncorr++;
            total++;
            if (corr_cnt !== CNTW'(m_corr) || uncorr_cnt !== CNTW'(m_uncorr)) begin
                bad++; $display("FAIL dir%0d_counters: got %0d/%0d want %0d/%0d",
                                t, corr_cnt, uncorr_cnt, m_corr, m_uncorr);
            end
            total++;
            if (bus.out_valid !== 1'b0) begin
                bad++; $display("FAIL dir%0d_duplicate: got out_valid=%b want 0", t, bus.out_valid);
            end
        end
    endtask

    task automatic test_back_to_back;
        exp_t       q[$];
        exp_t       e;
        logic [7:0] words[5];
        bit         odds[5];
        int         sent = 0;
        int         rcvd = 0;
        logic [9:0] held = '0;
        for (int i = 0; i < 5; i++) begin
            odds[i]  = 1'($urandom);
            words[i] = gen_word(odds[i]);
        end
        for (int c = 0; c < 16; c++) begin
            total++;
            if (corr_cnt !== CNTW'(m_corr) || uncorr_cnt !== CNTW'(m_uncorr)) begin
                bad++; $display("FAIL b2b_counters: got %0d/%0d want %0d/%0d", corr_cnt, uncorr_cnt, m_corr, m_uncorr);
            end
            bus.out_ready = !(c >= 2 && c <= 4);
            bus.in_valid  = (sent < 5);
            if (sent < 5) begin
                bus.code_in  = words[sent];
                bus.odd_mode = odds[sent];
            end
            #1;
            if (c == 2) begin
                total++;
                if (bus.out_valid !== 1'b1) begin
                    bad++; $display("FAIL b2b_first_out: got out_valid=%b want 1", bus.out_valid);
                end
                held = {bus.data_out, bus.err_single, bus.err_double, bus.err_pos};
            end
            if (c == 3 || c == 4) begin
                total++;
                if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                    {bus.data_out, bus.err_single, bus.err_double, bus.err_pos} !== held) begin
                    bad++; $display("FAIL b2b_hold c%0d: got v=%b rdy=%b out=%h want v=1 rdy=0 out=%h", c,
                                    bus.out_valid, bus.in_ready,
                                    {bus.data_out, bus.err_single, bus.err_double, bus.err_pos}, held);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL b2b_extra: got unexpected word want none");
                end else begin
                    e = q.pop_front();
                    if ({bus.data_out, bus.err_single, bus.err_double, bus.err_pos} !== {e.data, e.s, e.d, e.pos}) begin
                        bad++; $display("FAIL b2b_word%0d: got %h want %h", rcvd,
                                        {bus.data_out, bus.err_single, bus.err_double, bus.err_pos},
                                        {e.data, e.s, e.d, e.pos});
                    end
                    if (e.s && m_corr < CMAX)   m_corr++;
                    if (e.d && m_uncorr < CMAX) m_uncorr++;
                end
                rcvd++;
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model(words[sent], odds[sent]));
                sent++;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        total++;
        if (rcvd != 5 || q.size() != 0) begin
            bad++; $display("FAIL b2b_count: got rcvd=%0d pending=%0d want 5/0", rcvd, q.size());
        end
    endtask

    task automatic test_random;
        exp_t       q[$];
        exp_t       e;
        bit         prev_stall = 1'b0;
        logic [9:0] prev_out = '0;
        logic [9:0] cur;
        logic [7:0] cw;
        bit         odd;
        for (int c = 0; c < 320; c++) begin
            total++;
            if (corr_cnt !== CNTW'(m_corr) || uncorr_cnt !== CNTW'(m_uncorr)) begin
                bad++; $display("FAIL rnd_counters c%0d: got %0d/%0d want %0d/%0d", c, corr_cnt, uncorr_cnt, m_corr, m_uncorr);
            end
            cur = {bus.data_out, bus.err_single, bus.err_double, bus.err_pos};
            if (prev_stall) begin
                total++;
                if (bus.out_valid !== 1'b1 || cur !== prev_out) begin
                    bad++; $display("FAIL rnd_hold c%0d: got v=%b out=%h want v=1 out=%h", c, bus.out_valid, cur, prev_out);
                end
            end
            odd = 1'($urandom);
            cw  = gen_word(odd);
            bus.code_in   = cw;
            bus.odd_mode  = odd;
            bus.in_valid  = (c < 300) && ($urandom_range(0, 3) != 0);
            bus.out_ready = (c >= 300) || ($urandom_range(0, 2) != 0);
            #1;
            total++;
            if (bus.in_ready !== !(bus.out_valid && !bus.out_ready)) begin
                bad++; $display("FAIL rnd_in_ready c%0d: got %b want %b", c, bus.in_ready, !(bus.out_valid && !bus.out_ready));
            end
            if (bus.out_valid && bus.out_ready) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL rnd_extra c%0d: got unexpected word want none", c);
                end else begin
                    e = q.pop_front();
                    if (cur !== {e.data, e.s, e.d, e.pos}) begin
                        bad++; $display("FAIL rnd_word c%0d: got data=%b s=%b d=%b pos=%0d want data=%b s=%b d=%b pos=%0d",
                                        c, bus.data_out, bus.err_single, bus.err_double, bus.err_pos,
                                        e.data, e.s, e.d, e.pos);
                    end
                    if (e.s && m_corr < CMAX)   m_corr++;
                    if (e.d && m_uncorr < CMAX) m_uncorr++;
                end
            end
            if (bus.in_valid && bus.in_ready) q.push_back(model(cw, odd));
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_out   = cur;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        total++;
        if (q.size() != 0) begin
            bad++; $display("FAIL rnd_lost: got %0d words pending want 0", q.size());
        end
    endtask

    task automatic test_saturation_clear;
        bit ok;
        int lat;
        bus.out_ready = 1'b1;
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        m_corr = 0; m_uncorr = 0;
        total++;
        if (corr_cnt !== '0 || uncorr_cnt !== '0) begin
            bad++; $display("FAIL clr_idle: got %0d/%0d want 0/0", corr_cnt, uncorr_cnt);
        end
        for (int n = 0; n < 5; n++) begin
            send(encode(4'($urandom), 1'b0) ^ (8'd1 << $urandom_range(0, 7)), 1'b0);
            wait_out(ok, lat);
            total++;
            if (!ok || bus.err_single !== 1'b1) begin
                bad++; $display("FAIL sat_single%0d: got ok=%b s=%b want 1/1", n, ok, bus.err_single);
            end
            @(negedge clk);
        end
        total++;
        if (corr_cnt !== 2'd3) begin
            bad++; $display("FAIL sat_value: got %0d want 3", corr_cnt);
        end
        send(8'h56, 1'b0);
        wait_out(ok, lat);
        @(negedge clk);
        send(8'h45, 1'b0);
        wait_out(ok, lat);
        total++;
        if (!ok) begin
            bad++; $display("FAIL clr_xfer_timeout: got no out_valid want out_valid");
        end
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        total++;
        if (corr_cnt !== '0 || uncorr_cnt !== '0) begin
            bad++; $display("FAIL clr_priority: got %0d/%0d want 0/0", corr_cnt, uncorr_cnt);
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int lat;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.code_in  = gen_word(1'b0);
            bus.odd_mode = 1'b0;
            @(negedge clk);
        end
        total++;
        if (bus.out_valid !== 1'b1) begin
            bad++; $display("FAIL mid_stream_active: got out_valid=%b want 1", bus.out_valid);
        end
        #2;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || {bus.data_out, bus.err_single, bus.err_double, bus.err_pos} !== 10'd0) begin
            bad++; $display("FAIL mid_reset_async: got v=%b out=%h want v=0 out=000", bus.out_valid,
                            {bus.data_out, bus.err_single, bus.err_double, bus.err_pos});
        end
        total++;
        if (corr_cnt !== '0 || uncorr_cnt !== '0) begin
            bad++; $display("FAIL mid_reset_counters: got %0d/%0d want 0/0", corr_cnt, uncorr_cnt);
        end
        m_corr = 0; m_uncorr = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL mid_in_ready: got %b want 1", bus.in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (bus.out_valid !== 1'b0) begin
                bad++; $display("FAIL mid_stale_word%0d: got out_valid=%b want 0", i, bus.out_valid);
            end
        end
        send(8'h45, 1'b0);
        wait_out(ok, lat);
        total++;
        if (!ok || {bus.data_out, bus.err_single, bus.err_double, bus.err_pos} !== {4'b1011, 1'b1, 1'b0, 4'd5}) begin
            bad++; $display("FAIL mid_after_reset: got ok=%b out=%h want ok=1 out=%h", ok,
                            {bus.data_out, bus.err_single, bus.err_double, bus.err_pos},
                            {4'b1011, 1'b1, 1'b0, 4'd5});
        end
        @(negedge clk);
        total++;
        if (corr_cnt !== 2'd1) begin
            bad++; $display("FAIL mid_count: got %0d want 1", corr_cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_saturation_clear();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
